// File: rtl/bidirectional_shift_reg.sv
// Serial-in, parallel-out shift register with a per-edge direction select.
// Each bit is a small mux cell choosing its lower or upper neighbour.

module bidirectional_shift_cell (
    input  logic from_lo,   // neighbour toward bit 0 (or datain at bit 0)
    input  logic from_hi,   // neighbour toward MSB (or datain at MSB)
    input  logic mode,
    output logic nxt
);
    // Left shift pulls from the lower neighbour, right shift from the upper.
    assign nxt = mode ? from_lo : from_hi;
endmodule

module bidirectional_shift_reg #(
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             datain,
    input  logic             mode,
    output logic [WIDTH-1:0] dataout
);
    logic [WIDTH-1:0] dataout_q;
    logic [WIDTH-1:0] dataout_d;
    logic [WIDTH-1:0] lo_src;
    logic [WIDTH-1:0] hi_src;
    logic [WIDTH-1:0] shift_nxt;

    // Serial bit enters at bit 0 on a left shift and at the MSB on a right shift.
    always_comb begin
        lo_src = {dataout_q[WIDTH-2:0], datain};
        hi_src = {datain, dataout_q[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bidirectional_shift_cell u_cell (
            .from_lo (lo_src[i]),
            .from_hi (hi_src[i]),
            .mode    (mode),
            .nxt     (shift_nxt[i])
        );
    end

    always_comb begin
        dataout_d = shift_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dataout_q <= RESET_VALUE;
        else        dataout_q <= dataout_d;
    end

    assign dataout = dataout_q;
endmodule

// File: tb/tb_bidirectional_shift_reg.sv
// Bench for bidirectional_shift_reg: directed plan plus random stream vs an arithmetic model.

module tb_bidirectional_shift_reg;
    logic       clk = 1'b0;
    logic       reset;
    logic       datain;
    logic       mode;
    logic [3:0] dout4;
    logic [7:0] dout8;

    int checks = 0;
    int errors = 0;
    int m4 = 0;
    int m8 = 0;

    always #5 clk = ~clk;

    bidirectional_shift_reg #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .datain(datain), .mode(mode), .dataout(dout4)
    );
    bidirectional_shift_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .datain(datain), .mode(mode), .dataout(dout8)
    );

    // Left: multiply by two, add the bit, drop overflow. Right: halve, add bit weight of MSB.
    function automatic int model_next(int q, int w, bit d, bit m);
        int full;
        full = (1 << w);
        if (m) return (q * 2 + int'(d)) % full;
        else   return q / 2 + int'(d) * (full / 2);
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One shift step: drive inputs, take the edge, compare both widths with the model.
    task automatic step(bit d, bit m, string tag);
        datain = d;
        mode   = m;
        @(posedge clk);
        m4 = model_next(m4, 4, d, m);
        m8 = model_next(m8, 8, d, m);
        #1;
        chk({tag, "_w4"}, {4'b0, dout4}, 8'(m4));
        chk({tag, "_w8"}, dout8, 8'(m8));
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        m4 = 0;
        m8 = 0;
        #1;
        chk("rst_async_w4", {4'b0, dout4}, 8'h00);
        chk("rst_async_w8", dout8, 8'h00);
        @(posedge clk);
        #1;
        chk("rst_hold_w4", {4'b0, dout4}, 8'h00);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        reset  = 1'b0;
        datain = 1'b0;
        mode   = 1'b1;
        #1;
        chk("reset_state_w4", {4'b0, dout4}, 8'h00);
        chk("reset_state_w8", dout8, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load a nonzero value, then reset between edges.
        step(1, 1, "pre");
        step(1, 1, "pre");
        chk("pre_nonzero", {4'b0, dout4}, 8'h03);
        do_reset();

        // Left fill
        step(1, 1, "lf"); chk("lf1", {4'b0, dout4}, 8'h01);
        step(1, 1, "lf"); chk("lf2", {4'b0, dout4}, 8'h03);
        step(0, 1, "lf"); chk("lf3", {4'b0, dout4}, 8'h06);
        step(0, 1, "lf"); chk("lf4", {4'b0, dout4}, 8'h0C);
        step(0, 1, "lf"); chk("lf5", {4'b0, dout4}, 8'h08);
        step(0, 1, "lf"); chk("lf6", {4'b0, dout4}, 8'h00);

        // Right fill
        step(1, 0, "rf"); chk("rf1", {4'b0, dout4}, 8'h08);
        step(1, 0, "rf"); chk("rf2", {4'b0, dout4}, 8'h0C);
        step(0, 0, "rf"); chk("rf3", {4'b0, dout4}, 8'h06);
        step(0, 0, "rf"); chk("rf4", {4'b0, dout4}, 8'h03);
        step(0, 0, "rf"); chk("rf5", {4'b0, dout4}, 8'h01);
        step(0, 0, "rf"); chk("rf6", {4'b0, dout4}, 8'h00);

        // Mixed direction, reversal takes effect on the next edge
        step(1, 1, "mx"); chk("mx1", {4'b0, dout4}, 8'h01);
        step(1, 1, "mx"); chk("mx2", {4'b0, dout4}, 8'h03);
        step(0, 0, "mx"); chk("mx3", {4'b0, dout4}, 8'h01);
        step(1, 1, "mx"); chk("mx4", {4'b0, dout4}, 8'h03);
        step(1, 0, "mx"); chk("mx5", {4'b0, dout4}, 8'h09);

        // Mid-operation reset
        do_reset();
        step(1, 1, "ld"); step(0, 1, "ld"); step(1, 1, "ld"); step(1, 1, "ld");
        chk("ld_1011", {4'b0, dout4}, 8'h0B);
        do_reset();
        step(1, 1, "post_rst"); chk("post_rst", {4'b0, dout4}, 8'h01);

        // WIDTH=8: shift 10110010 in MSB first
        do_reset();
        pat = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) step(pat[i], 1, "w8ld");
        chk("w8_b2", dout8, 8'hB2);
        step(0, 0, "w8r");
        chk("w8_59", dout8, 8'h59);

        // Random stream with occasional mid-stream reset
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
